// File: rtl/systolic_seq_ctrl.sv
// Operand sequencer for a ROWS x COLS MAC grid: reads K operand words, skews them
// onto the grid edges with per-lane valids, waits for the grid to drain, pulses done.
module systolic_seq_ctrl #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int DATA_WIDTH = 8,
    parameter int K_MAX      = 16,
    parameter int ADDR_WIDTH = $clog2(K_MAX),
    parameter int KLEN_WIDTH = $clog2(K_MAX + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [KLEN_WIDTH-1:0]      k_len,
    output logic                       busy,
    output logic                       done,
    output logic                       rd_en,
    output logic [ADDR_WIDTH-1:0]      rd_addr,
    input  logic [ROWS*DATA_WIDTH-1:0] a_rd_data,
    input  logic [COLS*DATA_WIDTH-1:0] b_rd_data,
    output logic [ROWS*DATA_WIDTH-1:0] a_edge,
    output logic [ROWS-1:0]            a_edge_valid,
    output logic [COLS*DATA_WIDTH-1:0] b_edge,
    output logic [COLS-1:0]            b_edge_valid,
    output logic [COLS-1:0]            c_edge_valid
);

    localparam int DRAIN_CYC  = ROWS + COLS;
    localparam int DCNT_WIDTH = $clog2(DRAIN_CYC + 1);
    localparam logic [KLEN_WIDTH-1:0] K_MAX_L    = KLEN_WIDTH'(K_MAX);
    localparam logic [DCNT_WIDTH-1:0] DRAIN_LAST = DCNT_WIDTH'(DRAIN_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        DRAIN,
        DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [KLEN_WIDTH-1:0]  klen_q, klen_d;
    logic [KLEN_WIDTH-1:0]  k_q, k_d;
    logic [DCNT_WIDTH-1:0]  drain_q, drain_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            klen_q  <= '0;
            k_q     <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            klen_q  <= klen_d;
            k_q     <= k_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d = state_q;
        klen_d  = klen_q;
        k_d     = k_q;
        drain_d = drain_q;
        rd_en   = 1'b0;
        done    = 1'b0;
        busy    = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (start) begin
                    klen_d = (k_len > K_MAX_L) ? K_MAX_L : k_len;
                    if (k_len == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = FEED;
                        k_d     = '0;
                    end
                end
            end
            FEED: begin
                rd_en = 1'b1;
                // k stops at K-1 so rd_addr keeps the last issued index afterwards
                if (k_q == klen_q - KLEN_WIDTH'(1)) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end else begin
                    k_d = k_q + KLEN_WIDTH'(1);
                end
            end
            DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q + DCNT_WIDTH'(1);
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign rd_addr = k_q[ADDR_WIDTH-1:0];

    // Read data returns one cycle after rd_en; this delayed strobe qualifies it.
    logic rd_en_d1;
    always_ff @(posedge clk) begin
        if (!rst_n) rd_en_d1 <= 1'b0;
        else        rd_en_d1 <= rd_en;
    end

    logic [ROWS-1:0] a_vld_q;
    logic [COLS-1:0] b_vld_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_vld_q <= '0;
            b_vld_q <= '0;
        end else begin
            a_vld_q[0] <= rd_en_d1;
            for (int unsigned i = 1; i < ROWS; i++) a_vld_q[i] <= a_vld_q[i-1];
            b_vld_q[0] <= rd_en_d1;
            for (int unsigned i = 1; i < COLS; i++) b_vld_q[i] <= b_vld_q[i-1];
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_a_lane
        logic [DATA_WIDTH-1:0] sr [r+1];
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                for (int unsigned j = 0; j < r + 1; j++) sr[j] <= '0;
            end else begin
                sr[0] <= a_rd_data[r*DATA_WIDTH +: DATA_WIDTH];
                for (int unsigned j = 1; j < r + 1; j++) sr[j] <= sr[j-1];
            end
        end
        assign a_edge[r*DATA_WIDTH +: DATA_WIDTH] = a_vld_q[r] ? sr[r] : '0;
    end

    for (genvar c = 0; c < COLS; c++) begin : g_b_lane
        logic [DATA_WIDTH-1:0] sr [c+1];
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                for (int unsigned j = 0; j < c + 1; j++) sr[j] <= '0;
            end else begin
                sr[0] <= b_rd_data[c*DATA_WIDTH +: DATA_WIDTH];
                for (int unsigned j = 1; j < c + 1; j++) sr[j] <= sr[j-1];
            end
        end
        assign b_edge[c*DATA_WIDTH +: DATA_WIDTH] = b_vld_q[c] ? sr[c] : '0;
    end

    assign a_edge_valid = a_vld_q;
    assign b_edge_valid = b_vld_q;
    assign c_edge_valid = b_vld_q;

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Scoreboard bench for systolic_seq_ctrl: a buffer model answers reads, pushes the
// expected skewed lane values, and a negedge monitor checks control and edge outputs.
module tb_systolic_seq_ctrl;

    localparam int R  = 4;
    localparam int C  = 4;
    localparam int DW = 8;
    localparam int KM = 16;
    localparam int KW = $clog2(KM + 1);
    localparam int AW = $clog2(KM);

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [KW-1:0]   k_len;
    logic            busy, done, rd_en;
    logic [AW-1:0]   rd_addr;
    logic [R*DW-1:0] a_rd_data;
    logic [C*DW-1:0] b_rd_data;
    logic [R*DW-1:0] a_edge;
    logic [R-1:0]    a_edge_valid;
    logic [C*DW-1:0] b_edge;
    logic [C-1:0]    b_edge_valid;
    logic [C-1:0]    c_edge_valid;

    systolic_seq_ctrl #(
        .ROWS(R),
        .COLS(C),
        .DATA_WIDTH(DW),
        .K_MAX(KM)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .k_len(k_len),
        .busy(busy),
        .done(done),
        .rd_en(rd_en),
        .rd_addr(rd_addr),
        .a_rd_data(a_rd_data),
        .b_rd_data(b_rd_data),
        .a_edge(a_edge),
        .a_edge_valid(a_edge_valid),
        .b_edge(b_edge),
        .b_edge_valid(b_edge_valid),
        .c_edge_valid(c_edge_valid)
    );

    always #5 clk = ~clk;

    int now = 0;
    always @(posedge clk) now <= now + 1;

    typedef struct {
        int          due;
        logic [DW-1:0] val;
    } ent_t;

    ent_t qa [R][$];
    ent_t qb [C][$];

    int checks = 0;
    int errors = 0;

    bit run_active = 1'b0;
    int t0 = 0;
    int keff = 0;
    int rd_cnt = 0;
    int done_cnt = 0;

    bit          pend_v = 1'b0;
    logic [AW-1:0] pend_addr = '0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] wa(input int k, input int r);
        return DW'(k + 1 + 32 * r);
    endfunction

    function automatic logic [DW-1:0] wb(input int k, input int c);
        return DW'(128 + 16 * c + k);
    endfunction

    // Operand buffer model: answers a read one cycle later, garbage otherwise.
    initial begin
        a_rd_data = '0;
        b_rd_data = '0;
        forever begin
            @(posedge clk);
            #1;
            if (pend_v) begin
                for (int r = 0; r < R; r++) begin
                    a_rd_data[r*DW +: DW] = wa(int'(pend_addr), r);
                    qa[r].push_back('{due: now + 1 + r, val: wa(int'(pend_addr), r)});
                end
                for (int c = 0; c < C; c++) begin
                    b_rd_data[c*DW +: DW] = wb(int'(pend_addr), c);
                    qb[c].push_back('{due: now + 1 + c, val: wb(int'(pend_addr), c)});
                end
            end else begin
                a_rd_data = $urandom;
                b_rd_data = $urandom;
            end
        end
    end

    // Monitor: control outputs from the run descriptor, edge lanes from the scoreboard.
    initial begin
        int   cy, dcyc;
        bit   exp_rd, exp_busy, exp_done, ev;
        ent_t e;
        forever begin
            @(negedge clk);
            if (now >= 1) begin
                cy       = now - t0;
                dcyc     = (keff == 0) ? 1 : keff + R + C + 1;
                exp_rd   = run_active && cy >= 1 && cy <= keff;
                exp_busy = run_active && cy >= 1 && cy <= dcyc;
                exp_done = run_active && cy == dcyc;
                chk("busy", 32'(busy), 32'(exp_busy));
                chk("done", 32'(done), 32'(exp_done));
                chk("rd_en", 32'(rd_en), 32'(exp_rd));
                if (exp_rd) chk("rd_addr", 32'(rd_addr), 32'(cy - 1));
                if (rd_en === 1'b1) rd_cnt++;
                if (done === 1'b1) done_cnt++;
                for (int r = 0; r < R; r++) begin
                    ev = (qa[r].size() > 0) && (qa[r][0].due == now);
                    chk($sformatf("a_valid%0d", r), 32'(a_edge_valid[r]), 32'(ev));
                    if (ev) begin
                        e = qa[r].pop_front();
                        chk($sformatf("a_data%0d", r), 32'(a_edge[r*DW +: DW]), 32'(e.val));
                    end else begin
                        chk($sformatf("a_zero%0d", r), 32'(a_edge[r*DW +: DW]), 32'(0));
                    end
                end
                for (int c = 0; c < C; c++) begin
                    ev = (qb[c].size() > 0) && (qb[c][0].due == now);
                    chk($sformatf("b_valid%0d", c), 32'(b_edge_valid[c]), 32'(ev));
                    chk($sformatf("c_valid%0d", c), 32'(c_edge_valid[c]), 32'(ev));
                    if (ev) begin
                        e = qb[c].pop_front();
                        chk($sformatf("b_data%0d", c), 32'(b_edge[c*DW +: DW]), 32'(e.val));
                    end else begin
                        chk($sformatf("b_zero%0d", c), 32'(b_edge[c*DW +: DW]), 32'(0));
                    end
                end
            end
            pend_v    = (rd_en === 1'b1) && (rst_n === 1'b1);
            pend_addr = rd_addr;
            if (rst_n !== 1'b1) begin
                for (int r = 0; r < R; r++) qa[r].delete();
                for (int c = 0; c < C; c++) qb[c].delete();
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm(input int kl);
        t0         = now;
        keff       = (kl > KM) ? KM : kl;
        rd_cnt     = 0;
        done_cnt   = 0;
        run_active = 1'b1;
    endtask

    task automatic start_run(input int kl);
        start = 1'b1;
        k_len = KW'(kl);
        arm(kl);
        tick();
        start = 1'b0;
        k_len = KW'($urandom);
    endtask

    task automatic finish_run(input string tag);
        int dcyc;
        dcyc = (keff == 0) ? 1 : keff + R + C + 1;
        repeat (dcyc) tick();
        run_active = 1'b0;
        chk({tag, "_rd_cycles"}, 32'(rd_cnt), 32'(keff));
        chk({tag, "_done_pulses"}, 32'(done_cnt), 32'(1));
    endtask

    initial begin
        int pending;
        rst_n = 1'b0;
        start = 1'b1;
        k_len = KW'(3);
        repeat (3) tick();
        start = 1'b0;
        rst_n = 1'b1;
        chk("rd_addr_rst", 32'(rd_addr), 32'(0));
        repeat (2) tick();

        start_run(3);
        finish_run("k3");

        repeat (2) tick();
        start_run(0);
        finish_run("k0");

        repeat (2) tick();
        start_run(20);
        finish_run("k20");
        chk("rd_addr_hold", 32'(rd_addr), 32'(15));

        repeat (2) tick();
        start_run(3);
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        start = 1'b1;
        k_len = KW'(3);
        tick();
        chk("ign_rd_cycles", 32'(rd_cnt), 32'(3));
        chk("ign_done_pulses", 32'(done_cnt), 32'(1));
        arm(3);
        tick();
        start = 1'b0;
        finish_run("held");

        repeat (2) tick();
        start_run(8);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        run_active = 1'b0;
        chk("abort_rd_cycles", 32'(rd_cnt), 32'(2));
        chk("abort_done_pulses", 32'(done_cnt), 32'(0));
        repeat (4) tick();
        start_run(2);
        finish_run("after_abort");

        repeat (3) tick();
        pending = 0;
        for (int r = 0; r < R; r++) pending += qa[r].size();
        for (int c = 0; c < C; c++) pending += qb[c].size();
        chk("sb_empty", 32'(pending), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/systolic_seq_ctrl.md
Name: systolic_seq_ctrl

Overview:
- Sequencer for a ROWS x COLS grid of MAC processing elements.
- On start, reads K operand words from an A buffer and a B buffer, one word per reduction step.
- Skews the words so that row r / column c enter the grid r / c cycles later, each with its own valid bit, and drives the top-edge partial-sum valid bits.
- Waits for the grid to drain, then pulses done. Sits between the operand buffers and the PE grid edge.

Parameters:
- ROWS, 4, number of PE rows (A lanes)
- COLS, 4, number of PE columns (B lanes)
- DATA_WIDTH, 8, operand width per lane
- K_MAX, 16, maximum reduction length
- ADDR_WIDTH, $clog2(K_MAX), operand buffer address width
- KLEN_WIDTH, $clog2(K_MAX+1), width of k_len

Ports:
- clk, in, 1, clock
- rst_n, in, 1, synchronous active-low reset
- start, in, 1, request a tile run; sampled only in IDLE
- k_len, in, KLEN_WIDTH, reduction length; sampled with accepted start
- busy, out, 1, high whenever state != IDLE
- done, out, 1, one-cycle pulse at end of run
- rd_en, out, 1, read strobe to both A and B buffers
- rd_addr, out, ADDR_WIDTH, reduction index k
- a_rd_data, in, ROWS*DATA_WIDTH, A word; valid the cycle after rd_en; lane r = bits [r*DW +: DW]
- b_rd_data, in, COLS*DATA_WIDTH, B word; valid the cycle after rd_en
- a_edge, out, ROWS*DATA_WIDTH, skewed A data to the left grid edge
- a_edge_valid, out, ROWS, per-row valid
- b_edge, out, COLS*DATA_WIDTH, skewed B data to the top grid edge
- b_edge_valid, out, COLS, per-column valid
- c_edge_valid, out, COLS, top-edge partial-sum valid; c data is tied to zero outside this block

Behaviour:

Reset:
- rst_n=0 at a clock edge forces state IDLE and clears counters and all skew and pipeline registers.
- All outputs are 0 in the next cycle. This applies mid-run as well: the run is abandoned and done is not pulsed.

FSM states: IDLE, FEED, DRAIN, DONE.
- IDLE: busy=0. start=1 latches k_len as K.
  - K > K_MAX is clamped to K_MAX.
  - K=0 goes to DONE.
  - Otherwise goes to FEED with k=0.
- FEED: rd_en=1, rd_addr=k, k increments each cycle. After issuing k=K-1, go to DRAIN with drain counter = 0.
- DRAIN: rd_en=0. Lasts exactly ROWS+COLS cycles, then go to DONE.
- DONE: done=1 for one cycle, then IDLE.

Start handling:
- start is ignored in FEED, DRAIN and DONE.
- A start held high during DONE is accepted in the following IDLE cycle.

Timing (start accepted at edge of cycle 0):
- rd_en is high during cycles 1..K.
- done is high in cycle K+ROWS+COLS+1.
- For K=0, done is high in cycle 1.

Skew pipeline:
- The returned word is registered once (stage 0).
- Lane r of A passes through r further registers. a_edge_valid[r] equals rd_en delayed 2+r cycles.
- B is identical with column index c. c_edge_valid[c] = b_edge_valid[c].
- Edge data lanes output 0 whenever the matching valid is 0.
- Skew registers shift every cycle regardless of state, so the tail of a run drains correctly during DRAIN.

Other rules:
- rd_addr holds its last value outside FEED; it is don't-care when rd_en=0 but must not be X after reset (reset value 0).
- The DRAIN length ROWS+COLS guarantees the last valid has left every edge lane (max delay 2+max(ROWS,COLS)-1) before done.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with start=1 -> busy, done, rd_en, all edge valids = 0, and all edge data = 0.
- ROWS=COLS=4, k_len=3, A word k = {4{k+1}} -> rd_en cycles 1-3 with rd_addr 0,1,2.
  - a_edge_valid[0] high cycles 3-5 with data 1,2,3.
  - a_edge_valid[3] high cycles 6-8.
  - done is high only in cycle 12; busy is high cycles 1-12.
- k_len=0 -> no rd_en; done in cycle 1; all edge valids stay 0.
- k_len=20 (K_MAX=16) -> exactly 16 rd_en cycles, addr 0..15; done in cycle 25.
- start pulsed in cycles 4 and 12 of a k_len=3 run -> both ignored. start held through cycle 13 -> a new run is accepted at cycle 13, with first rd_en in cycle 14.
- rst_n=0 in cycle 2 of a k_len=8 run -> from cycle 3 all outputs are 0 and state is IDLE; no done pulse; a new start with k_len=2 then completes normally, with done 11 cycles after acceptance.
